// File: rtl/dmem_io_ctrl.sv
// Data-memory and memory-mapped I/O controller: word RAM, output registers and a synchronised input port.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module dmem_io_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] IO_BASE     = 32'h0000_1000,
  parameter int unsigned NUM_IO_OUT  = 2,
  parameter int unsigned IO_OUT_W    = 12,
  parameter int unsigned IO_IN_W     = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [31:0]                    req_addr,
  input  logic [31:0]                    req_wdata,
  input  logic [1:0]                     req_size,
  input  logic                           req_sext,
  output logic                           resp_valid,
  output logic [31:0]                    resp_rdata,
  output logic                           resp_err,
  output logic [NUM_IO_OUT*IO_OUT_W-1:0] io_out,
  input  logic [IO_IN_W-1:0]             io_in
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned RAM_SHIFT = AW + 2;
  localparam logic [29:0] IO_BASE_W = IO_BASE[31:2];
  localparam logic [29:0] IO_IN_OFF = 30'(NUM_IO_OUT);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, wdata_q;
  logic [1:0]            size_q;
  logic                  we_q, sext_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [IO_IN_W-1:0]    sync1_q, sync2_q;
  logic [IO_OUT_W-1:0]   io_q [NUM_IO_OUT];
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  capture;
  logic [31:0]           cur_addr, cur_wdata;
  logic [1:0]            cur_size;
  logic                  cur_we, cur_sext;
  logic                  is_byte, is_half;
  logic [31:0]           addr_eff;
  logic                  misalign, fault_mis;
  logic                  is_ram, is_io_out, is_io_in;
  logic [29:0]           word_addr, io_off;
  logic [AW-1:0]         ram_idx;
  logic [31:0]           ram_word, byte_sh;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [IO_OUT_W-1:0]   io_rd;
  logic [31:0]           rd_val;
  logic                  err_val;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic                  ram_we, io_we;

  // Ready is gated by rst_n so it is low throughout reset and rises as soon as reset releases.
  assign req_ready  = rst_n && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // In IDLE the live request is decoded so zero-wait reads and acceptance-edge writes see it directly.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_size  = req_size;
      cur_we    = req_we;
      cur_sext  = req_sext;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_size  = size_q;
      cur_we    = we_q;
      cur_sext  = sext_q;
    end
  end

  assign is_byte = (cur_size == 2'd0);
  assign is_half = (cur_size == 2'd1);

  always_comb begin
    addr_eff = cur_addr;
    misalign = 1'b0;
    if (is_half) begin
      misalign    = cur_addr[0];
      addr_eff[0] = 1'b0;
    end else if (!is_byte) begin
      misalign      = |cur_addr[1:0];
      addr_eff[1:0] = 2'b00;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_mis = misalign;
`else
  assign fault_mis = 1'b0;
`endif

  assign word_addr = addr_eff[31:2];
  assign io_off    = word_addr - IO_BASE_W;
  assign is_ram    = ((addr_eff >> RAM_SHIFT) == 32'd0);
  assign is_io_out = (word_addr >= IO_BASE_W) && (io_off < IO_IN_OFF);
  assign is_io_in  = (word_addr >= IO_BASE_W) && (io_off == IO_IN_OFF);
  assign ram_idx   = addr_eff[AW+1:2];
  assign ram_word  = mem[ram_idx];
  assign byte_sh   = ram_word >> {addr_eff[1:0], 3'b000};
  assign byte_v    = byte_sh[7:0];
  assign half_v    = addr_eff[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    io_rd = '0;
    for (int k = 0; k < NUM_IO_OUT; k++) begin
      if (io_off == 30'(k)) io_rd = io_q[k];
    end
  end

  always_comb begin
    rd_val  = '0;
    err_val = 1'b0;
    if (fault_mis) begin
      err_val = 1'b1;
    end else if (is_ram) begin
      if (is_byte) begin
        rd_val = cur_sext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end else if (is_half) begin
        rd_val = cur_sext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end else begin
        rd_val = ram_word;
      end
    end else if (is_io_out) begin
      rd_val = 32'(io_rd);
    end else if (is_io_in) begin
      rd_val  = 32'(sync2_q);
      err_val = cur_we;
    end else begin
      err_val = 1'b1;
    end
    if (cur_we) rd_val = '0;
  end

  // Sub-word store data is replicated across lanes; the byte enables pick the lane that lands.
  always_comb begin
    be    = 4'b1111;
    wlane = cur_wdata;
    if (is_byte) begin
      be    = 4'b0001 << addr_eff[1:0];
      wlane = {4{cur_wdata[7:0]}};
    end else if (is_half) begin
      be    = addr_eff[1] ? 4'b1100 : 4'b0011;
      wlane = {2{cur_wdata[15:0]}};
    end
  end

  assign ram_we = accept && req_we && is_ram && !fault_mis;
  assign io_we  = accept && req_we && !is_ram && is_io_out && !fault_mis;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign capture = (state_d == RESP) && (state_q != RESP);
  assign rdata_d = capture ? rd_val  : rdata_q;
  assign err_d   = capture ? err_val : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        sext_q  <= req_sext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_IO_OUT; k++) io_q[k] <= '0;
    end else if (io_we) begin
      for (int k = 0; k < NUM_IO_OUT; k++) begin
        if (io_off == 30'(k)) io_q[k] <= cur_wdata[IO_OUT_W-1:0];
      end
    end
  end

  for (genvar k = 0; k < NUM_IO_OUT; k++) begin : g_io_out
    assign io_out[k*IO_OUT_W +: IO_OUT_W] = io_q[k];
  end

endmodule

// File: doc/dmem_io_ctrl.md
DMEM_IO_CTRL -- requirements
Module: dmem_io_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: RAM size in 32-bit words; power of 2, minimum 4.
REQ-002 SHALL have parameter IO_BASE, default 32'h0000_1000: byte address of the first I/O register; word-aligned.
REQ-003 SHALL have parameters NUM_IO_OUT (default 2), IO_OUT_W (default 12) and IO_IN_W (default 16): output register count, output register width and input port width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, range 0-15: extra wait states per access.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present; req_ready  out  1  controller can accept.
REQ-008 req_we  in  1  1 = write, 0 = read; req_addr  in  32  byte address; req_wdata  in  32  write data.
REQ-009 req_size  in  2  access size: 0 = byte, 1 = half, 2 or 3 = word; req_sext  in  1  sign-extend sub-word reads.
REQ-010 resp_valid  out  1  one-cycle response strobe; resp_rdata  out  32  read data; resp_err  out  1  access fault.
REQ-011 io_out  out  NUM_IO_OUT*IO_OUT_W  output registers concatenated, register k at bits [k*IO_OUT_W +: IO_OUT_W].
REQ-012 io_in  in  IO_IN_W  asynchronous external inputs.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; the address, data, size, we and sext fields SHALL be latched at that edge.
REQ-015 FSM transitions:
- IDLE->RESP on acceptance when WAIT_CYCLES=0.
- IDLE->WAIT on acceptance otherwise, loading a down-counter with WAIT_CYCLES-1.
- WAIT->RESP when the counter reaches 0.
- RESP->IDLE unconditionally.
REQ-016 resp_valid SHALL be 1 for exactly the one cycle spent in RESP; the first RESP cycle SHALL follow the acceptance edge by WAIT_CYCLES+1 cycles, and back-to-back requests SHALL sustain one access every WAIT_CYCLES+2 cycles.
REQ-017 A RAM region access SHALL be one with req_addr < 4*DEPTH; it SHALL address word req_addr[log2(DEPTH)+1:2].
REQ-018 Writes SHALL commit at the acceptance edge using byte enables: byte writes lane addr[1:0], half writes lanes {addr[1],0} and {addr[1],1}, word writes all four lanes; unselected lanes SHALL be unchanged.
REQ-019 Read data SHALL be captured on entry to RESP, so a read issued after a completed write to the same word SHALL return the new data.
REQ-020 Sub-word reads SHALL right-justify the selected lane(s); with req_sext=1 bits above the lane SHALL replicate the selected lane's own MSB; otherwise they SHALL be zero.
REQ-021 Address IO_BASE+4k, for k<NUM_IO_OUT, SHALL be register k:
- a write loads req_wdata[IO_OUT_W-1:0] regardless of size;
- a read returns that register zero-extended.
REQ-022 Address IO_BASE+4*NUM_IO_OUT SHALL be read-only: a read returns synchronised io_in zero-extended, and a write is ignored with resp_err=1.
REQ-023 io_in SHALL pass through a two-flop synchroniser before it can be read.
REQ-024 Any address outside the RAM and I/O regions SHALL read 0, ignore writes, and set resp_err=1.
REQ-025 resp_rdata SHALL be 0 for write responses, and resp_rdata and resp_err SHALL hold their values until the next RESP.

Reset
REQ-026 While rst_n=0:
- FSM = IDLE, wait counter = 0;
- req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0;
- every io_out register = 0 and the synchroniser flops = 0.
REQ-027 RAM contents SHALL not be reset.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the transaction with no response; a write already committed at acceptance SHALL remain in memory.
REQ-029 req_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, misaligned accesses SHALL fault: a half with addr[0]=1 or a word with addr[1:0]!=0 SHALL suppress the write, return rdata 0 and set resp_err=1.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, the offending low address bits SHALL be treated as 0 (access forced aligned) and resp_err SHALL be 0 for such accesses.

Verification
REQ-032 Reset then word write 0xDEADBEEF to 0x10, then read 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid one cycle after each acceptance.
REQ-033 Byte write 0x80 to 0x13, then byte read 0x13 with sext=1 -> 0xFFFFFF80; with sext=0 -> 0x00000080; word read 0x10 -> 0x80ADBEEF.
REQ-034 WAIT_CYCLES=3, continuous req_valid -> resp_valid 4 cycles after each acceptance, req_ready low for 4 cycles between acceptances.
REQ-035 Write 0xABC to IO_BASE+4 -> io_out[23:12]=0xABC; io_in=0x1234 held 3 cycles then read IO_BASE+8 -> 0x00001234.
REQ-036 Read 0x0000_2000 -> rdata 0, resp_err=1; half write to 0x11 -> with DMEM_MISALIGN_TRAP_EN: resp_err=1 and memory unchanged; without it: lanes 0-1 of word 0x10 written, resp_err=0.
REQ-037 rst_n pulsed low while in WAIT -> no resp_valid, io_out=0, req_ready=1 in the first cycle after release.
